// File: rtl/glyph_rain_engine.sv
// Glyph-rain renderer: per-column drop state refreshed by a once-per-frame column sweep, 2-cycle render pipeline.
// Optional macro GLYPH_RAIN_MUTATE_EN adds per-column glyph seeds that flicker during the sweep.
module glyph_rain_engine #(
  parameter int          COLS        = 80,
  parameter int          ROWS        = 40,
  parameter int          CELL_W_LOG2 = 3,
  parameter int          CELL_H      = 12,
  parameter int          TAIL_LEN    = 8,
  parameter int          SPAWN_LOG2  = 3,
  parameter int          GLYPH_W     = 6,
  parameter int          HEAD_W      = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  input  logic                   display_on,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [1:0]             palette_sel,
  output logic [GLYPH_W-1:0]     glyph_index,
  output logic [CELL_W_LOG2-1:0] glyph_x,
  output logic [3:0]             glyph_y,
  input  logic                   glyph_pixel,
  output logic [5:0]             rgb,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   sweep_busy
);
  localparam int CX_W  = 10 - CELL_W_LOG2;
  localparam int CY_W  = 8;
  localparam int D_W   = CY_W + 2;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                     state;
  logic [COL_W-1:0]           k;
  logic [15:0]                lfsr, lfsr_nxt, frame;
  logic                       vsync_prev;
  logic [COLS-1:0]            active, speed;
  logic [COLS-1:0][HEAD_W-1:0] head;
  logic [GLYPH_W-1:0]         seed_term;

  logic [3:0]       gy, gy_nxt;
  logic [CY_W-1:0]  cy, cy_nxt;
  logic [CX_W-1:0]  cx;
  logic             col_ok, in_grid, in_tail;
  logic [COL_W-1:0] col;
  logic [D_W-1:0]   d;
  logic [1:0]       level;
  logic [GLYPH_W-1:0] gsum;

  logic       lit1, tip1, hs1, vs1;
  logic [1:0] lvl1, pal1;
  logic [5:0] shade;

  // Row counters advance on the hpos==0 sample and that sample already sees the new value.
  always_comb begin
    gy_nxt = gy;
    cy_nxt = cy;
    if (hpos == '0) begin
      if (vpos == '0) begin
        gy_nxt = '0;
        cy_nxt = '0;
      end else if (gy == 4'(CELL_H - 1)) begin
        gy_nxt = '0;
        cy_nxt = cy + 1'b1;
      end else begin
        gy_nxt = gy + 1'b1;
      end
    end
  end

  assign cx      = hpos[9:CELL_W_LOG2];
  assign col_ok  = cx < CX_W'(COLS);
  assign in_grid = col_ok && (cy_nxt < CY_W'(ROWS));
  assign col     = col_ok ? COL_W'(cx) : '0;
  // d is two's complement; the MSB flags rows below the head
  assign d       = D_W'(head[col]) - D_W'(cy_nxt);
  assign in_tail = !d[D_W-1] && (d < D_W'(TAIL_LEN));
  assign level   = 2'd3 - 2'({d, 2'b00} / (D_W+2)'(TAIL_LEN));
  assign gsum    = GLYPH_W'(16'(cx) * 16'd7 + 16'(cy_nxt) * 16'd13 + 16'(seed_term));

`ifdef GLYPH_RAIN_MUTATE_EN
  logic [COLS-1:0][GLYPH_W-1:0] seed;
  assign seed_term = col_ok ? seed[col] : '0;
`else
  assign seed_term = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gy <= '0; cy <= '0;
      glyph_index <= '0; glyph_x <= '0; glyph_y <= '0;
      lit1 <= 1'b0; tip1 <= 1'b0; lvl1 <= '0; pal1 <= '0; hs1 <= 1'b0; vs1 <= 1'b0;
    end else begin
      gy <= gy_nxt;
      cy <= cy_nxt;
      glyph_index <= gsum;
      glyph_x     <= hpos[CELL_W_LOG2-1:0];
      glyph_y     <= gy_nxt;
      lit1 <= display_on && in_grid && active[col] && in_tail;
      tip1 <= (d == '0);
      lvl1 <= level;
      pal1 <= palette_sel;
      hs1  <= hsync_in;
      vs1  <= vsync_in;
    end
  end

  always_comb begin
    shade = '0;
    case (pal1)
      2'd0:    shade = {2'b00, lvl1, 2'b00};
      2'd1:    shade = {lvl1, 1'b0, lvl1[1], 2'b00};
      2'd2:    shade = {2'b00, lvl1, lvl1};
      default: shade = {lvl1, lvl1, lvl1};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= '0; hsync_out <= 1'b0; vsync_out <= 1'b0;
    end else begin
      rgb       <= (lit1 && glyph_pixel) ? (tip1 ? 6'h3F : shade) : '0;
      hsync_out <= hs1;
      vsync_out <= vs1;
    end
  end

  assign lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

  // Column sweep: one column per cycle; decisions use the LFSR value before it advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE; k <= '0; frame <= '0; lfsr <= LFSR_SEED; vsync_prev <= 1'b0;
      sweep_busy <= 1'b0; active <= '0; speed <= '0; head <= '0;
`ifdef GLYPH_RAIN_MUTATE_EN
      seed <= '0;
`endif
    end else begin
      vsync_prev <= vsync_in;
      case (state)
        IDLE: if (vsync_in && !vsync_prev) begin
          state      <= SWEEP;
          k          <= '0;
          frame      <= frame + 1'b1;
          sweep_busy <= 1'b1;
        end
        SWEEP: begin
          lfsr <= lfsr_nxt;
          if (active[k]) begin
`ifdef GLYPH_RAIN_MUTATE_EN
            if (lfsr[1:0] == 2'b11) seed[k] <= seed[k] + 1'b1;
`endif
            if (head[k] == HEAD_W'(ROWS + TAIL_LEN - 1)) active[k] <= 1'b0;
            else if (speed[k] || frame[0]) head[k] <= head[k] + 1'b1;
          end else if (lfsr[SPAWN_LOG2-1:0] == '0) begin
            active[k] <= 1'b1;
            head[k]   <= '0;
            speed[k]  <= lfsr[15];
          end
          if (k == COL_W'(COLS - 1)) begin
            state      <= IDLE;
            sweep_busy <= 1'b0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/glyph_rain_engine.md
Name: glyph_rain_engine

Overview:
- Parametrised next-generation glyph-rain renderer for the TinyVGA glyph-mode display.
- Keeps per-column falling-drop state in registers and updates it with a column-sweep FSM once per frame.
- Tracks glyph cell coordinates with counters instead of a divider, and drives an external glyph ROM.
- Produces pipelined 6-bit RGB plus delayed sync, ready for the PMOD pin mapping.

Parameters:
- COLS, 80: number of glyph columns.
- ROWS, 40: number of glyph rows.
- CELL_W_LOG2, 3: log2 of glyph cell width in pixels.
- CELL_H, 12: glyph cell height in lines.
- TAIL_LEN, 8: drop length in cells, head included; must be a multiple of 4.
- SPAWN_LOG2, 3: an idle column spawns with probability 1/2^SPAWN_LOG2 per frame.
- GLYPH_W, 6: glyph index width.
- HEAD_W, 7: head-row register width; must hold ROWS+TAIL_LEN.
- LFSR_SEED, 16'hACE1: reset value of the LFSR; must be nonzero.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- hpos  in  10  horizontal pixel position.
- vpos  in  10  vertical pixel position.
- display_on  in  1  active video.
- hsync_in  in  1  horizontal sync from the timing generator.
- vsync_in  in  1  vertical sync from the timing generator; active-high pulse.
- palette_sel  in  2  palette select.
- glyph_index  out  GLYPH_W  glyph ROM character index.
- glyph_x  out  CELL_W_LOG2  glyph ROM column.
- glyph_y  out  4  glyph ROM row.
- glyph_pixel  in  1  glyph ROM output; combinational from glyph_* outputs.
- rgb  out  6  color as {R[1:0],G[1:0],B[1:0]}.
- hsync_out  out  1  hsync_in delayed 2 cycles.
- vsync_out  out  1  vsync_in delayed 2 cycles.
- sweep_busy  out  1  high while the column sweep runs.

Behaviour:
- Reset (asynchronous, active-high):
  - All columns inactive; head=0, speed=0, seed=0.
  - LFSR=LFSR_SEED; frame counter=0; FSM in IDLE.
  - All outputs 0.
- Cell tracking, on the sample where hpos==0:
  - If vpos==0: gy=0, cy=0.
  - Else gy increments; gy wraps from CELL_H-1 to 0 and cy increments.
  - cx = hpos>>CELL_W_LOG2; gx = hpos low bits.
- Pipeline:
  - Inputs sampled at edge N.
  - glyph_index/x/y are registered at N+1.
  - glyph_pixel is sampled at N+2 together with the registered rgb, hsync_out and vsync_out.
  - Fixed latency of 2 cycles.
- Glyph index: low GLYPH_W bits of (cx*7 + cy*13 + seed[cx]).
- Render, with d = head[cx] - cy:
  - rgb=0 when any of: display_on low, cx>=COLS, cy>=ROWS, column inactive, d<0, d>=TAIL_LEN, glyph_pixel=0.
  - d==0: rgb=6'b111111.
  - Otherwise shade level L = 3 - (4*d)/TAIL_LEN.
  - palette_sel 0 (green): {00,L,00}.
  - palette_sel 1 (amber): {L,L>>1,00}.
  - palette_sel 2 (cyan): {00,L,L}.
  - palette_sel 3 (grey): {L,L,L}.
- FSM IDLE -> SWEEP:
  - Triggered by a rising edge of vsync_in, detected with one registered prior value.
  - The frame counter increments on entry.
- SWEEP, one column per cycle, index k from 0 to COLS-1; the LFSR advances every SWEEP cycle.
  - LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400.
  - Active column with head == ROWS+TAIL_LEN-1: becomes inactive.
  - Active column otherwise: head += 1 if speed=1 or frame[0]=1; else head is held.
  - Inactive column with LFSR[SPAWN_LOG2-1:0]==0: becomes active, head=0, speed=LFSR[15].
- SWEEP -> IDLE after k==COLS-1; sweep_busy is high exactly COLS cycles.
- A vsync rising edge during SWEEP is ignored.
- display_on must be low during SWEEP; rendering during SWEEP uses the mid-update state and is unspecified.
- Reset asserted mid-sweep: returns to IDLE with all state cleared.

Optional Feature:
- Macro: GLYPH_RAIN_MUTATE_EN.
- Defined: during SWEEP, an active column's seed increments when LFSR[1:0]==2'b11, producing flickering glyphs.
- Undefined: seeds stay 0 and the mutate logic is absent.

Test Plan:
- Reset asserted, then idle with no vsync -> rgb=0, glyph outputs 0, sweep_busy=0, all columns inactive.
- One vsync pulse with SPAWN_LOG2=1 and COLS=4 -> sweep_busy high exactly 4 cycles; spawned columns match a reference LFSR seeded 16'hACE1.
- Force column 2 active, head=5, TAIL_LEN=8, palette_sel=0, glyph_pixel=1:
  - cell (2,5) -> rgb=6'h3F.
  - cell (2,3) -> rgb=6'b001000 (L=2).
  - cell (2,6) -> rgb=0.
- Step hpos and vpos in place -> glyph_x/glyph_y appear 1 cycle later, rgb/hsync_out/vsync_out 2 cycles later; gy wraps after 12 lines and cy becomes 1.
- Head at ROWS+TAIL_LEN-1, then a vsync pulse -> column inactive afterwards; a second vsync pulse during SWEEP -> sweep length unchanged.
- With GLYPH_RAIN_MUTATE_EN defined, run 64 frames -> at least one seed is nonzero; undefined -> glyph_index equals (cx*7+cy*13) mod 64 throughout.
